// File: rtl/digital_clock.sv
// digital_clock: 24-hour HH:MM:SS time-of-day counter.
// A prescaler divides clk down to a one-cycle tick every CLK_FREQ cycles.
// Each tick advances six cascaded BCD digits. Every digit is a register,
// so no input reaches an output combinationally. Reset is synchronous and
// active-high. It clears the prescaler and the time, and it overrides a
// tick that lands on the same edge.
module digital_clock #(
   parameter int CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic [3:0] hour_ones,
   output logic [3:0] hour_tens
);

   // The prescaler is at least 1 bit wide, so CLK_FREQ = 1 still builds.
   // In that case the counter stays at 0 and tick is always high.
   localparam int            PW    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [PW-1:0] P_MAX = PW'(CLK_FREQ - 1);

   logic [PW-1:0] prescaler;
   logic          tick;
   logic          carry_so;
   logic          carry_st;
   logic          carry_mo;
   logic          carry_mt;
   logic          hour_is_23;

   assign tick = (prescaler == P_MAX);

   // Prescaler: counts 0 .. CLK_FREQ-1, then wraps on the tick cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler <= '0;
      end else if (tick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + PW'(1);
      end
   end

   // Ripple enables. Each stage advances only when every lower stage wraps
   // on this tick, so a full carry chain settles within a single cycle.
   always_comb begin
      carry_so   = tick     && (sec_ones == 4'd9);
      carry_st   = carry_so && (sec_tens == 4'd5);
      carry_mo   = carry_st && (min_ones == 4'd9);
      carry_mt   = carry_mo && (min_tens == 4'd5);
      hour_is_23 = (hour_tens == 4'd2) && (hour_ones == 4'd3);
   end

   // Seconds digits: units wrap 9 -> 0, tens wrap 5 -> 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         sec_ones <= 4'd0;
         sec_tens <= 4'd0;
      end else begin
         if (tick) begin
            sec_ones <= (sec_ones == 4'd9) ? 4'd0 : sec_ones + 4'd1;
         end
         if (carry_so) begin
            sec_tens <= (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
         end
      end
   end

   // Minutes digits: same pattern as seconds, driven by the seconds carry.
   always_ff @(posedge clk) begin
      if (reset) begin
         min_ones <= 4'd0;
         min_tens <= 4'd0;
      end else begin
         if (carry_st) begin
            min_ones <= (min_ones == 4'd9) ? 4'd0 : min_ones + 4'd1;
         end
         if (carry_mo) begin
            min_tens <= (min_tens == 4'd5) ? 4'd0 : min_tens + 4'd1;
         end
      end
   end

   // Hours: 23 wraps to 00. Otherwise units roll 9 -> 0 into the tens digit.
   always_ff @(posedge clk) begin
      if (reset) begin
         hour_ones <= 4'd0;
         hour_tens <= 4'd0;
      end else if (carry_mt) begin
         if (hour_is_23) begin
            hour_ones <= 4'd0;
            hour_tens <= 4'd0;
         end else if (hour_ones == 4'd9) begin
            hour_ones <= 4'd0;
            hour_tens <= hour_tens + 4'd1;
         end else begin
            hour_ones <= hour_ones + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_digital_clock.sv
// tb_digital_clock: three clock instances share one system clock.
//   inst 0: CLK_FREQ = 4. Prescaler timing, held reset, reset coinciding
//           with a tick, and random reset pulses.
//   inst 1: CLK_FREQ = 1. Runs a full day through every carry and the
//           midnight wrap.
//   inst 2: CLK_FREQ = 1. Reset is asserted at 12:34:56, on an edge where
//           a tick is also present.
// The reference model holds the time as a plain count of seconds since
// midnight. It converts that count to HH:MM:SS with division only.
module tb_digital_clock;

   localparam int N_INST  = 3;
   localparam int DAY     = 86400;
   localparam int N_EDGES = DAY + 2;

   logic              clk;
   logic [N_INST-1:0] rst;
   logic [3:0]        so  [N_INST];
   logic [3:0]        st  [N_INST];
   logic [3:0]        mo  [N_INST];
   logic [3:0]        mt  [N_INST];
   logic [3:0]        ho  [N_INST];
   logic [3:0]        ht  [N_INST];
   logic [23:0]       tm  [N_INST];

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Reference model state: seconds since midnight plus prescaler phase.
   int secs [N_INST];
   int pcnt [N_INST];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   digital_clock #(.CLK_FREQ(4)) dut_a (
      .clk(clk), .reset(rst[0]),
      .sec_ones(so[0]), .sec_tens(st[0]), .min_ones(mo[0]),
      .min_tens(mt[0]), .hour_ones(ho[0]), .hour_tens(ht[0])
   );

   digital_clock #(.CLK_FREQ(1)) dut_b (
      .clk(clk), .reset(rst[1]),
      .sec_ones(so[1]), .sec_tens(st[1]), .min_ones(mo[1]),
      .min_tens(mt[1]), .hour_ones(ho[1]), .hour_tens(ht[1])
   );

   digital_clock #(.CLK_FREQ(1)) dut_c (
      .clk(clk), .reset(rst[2]),
      .sec_ones(so[2]), .sec_tens(st[2]), .min_ones(mo[2]),
      .min_tens(mt[2]), .hour_ones(ho[2]), .hour_tens(ht[2])
   );

   // Pack each instance as 24-bit BCD {HH,MM,SS}; e.g. 12:34:56 = 24'h123456.
   always_comb begin
      for (int i = 0; i < N_INST; i++) begin
         tm[i] = {ht[i], ho[i], mt[i], mo[i], st[i], so[i]};
      end
   end

   function automatic int freq_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic logic [23:0] to_bcd(input int s);
      int h;
      int m;
      int sc;
      h  = s / 3600;
      m  = (s / 60) % 60;
      sc = s % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
              4'(sc / 10), 4'(sc % 10)};
   endfunction

   // Legal means every digit is 0..9, the tens of minutes and seconds
   // are 0..5, and the hour is 0..23.
   function automatic bit is_legal(input logic [23:0] t);
      int h;
      if (t[23:20] > 4'd9 || t[19:16] > 4'd9 || t[15:12] > 4'd5 ||
          t[11:8] > 4'd9 || t[7:4] > 4'd5 || t[3:0] > 4'd9) return 1'b0;
      h = int'(t[23:20]) * 10 + int'(t[19:16]);
      return (h <= 23);
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [23:0] got,
                        input logic [23:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model, advanced on each rising edge.
   always @(posedge clk) begin
      for (int i = 0; i < N_INST; i++) begin
         if (rst[i]) begin
            secs[i] <= 0;
            pcnt[i] <= 0;
         end else if (pcnt[i] == freq_of(i) - 1) begin
            pcnt[i] <= 0;
            secs[i] <= (secs[i] + 1) % DAY;
         end else begin
            pcnt[i] <= pcnt[i] + 1;
         end
      end
   end

   // Scoreboard: on every falling edge, compare each DUT with the model
   // and check that every digit is legal.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < N_INST; i++) begin
            check($sformatf("model_%0d", i), tm[i], to_bcd(secs[i]));
            check($sformatf("legal_%0d", i), 24'(is_legal(tm[i])), 24'd1);
         end
      end
   end

   // ---------------- driver ----------------
   initial begin
      int  rel_a;
      int  hold_a;
      int  held_start;
      bit  tick_rst_done;
      logic [23:0] exp_b;

      rst           = '1;
      rel_a         = 0;
      hold_a        = 0;
      tick_rst_done = 1'b0;
      held_start    = $urandom_range(21, 59);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      check("reset_a", tm[0], 24'h000000);
      check("reset_b", tm[1], 24'h000000);
      check("reset_c", tm[2], 24'h000000);
      rst = '0;

      for (int k = 1; k <= N_EDGES; k++) begin
         @(posedge clk);
         @(negedge clk);

         // Instance 0: the time stays zero while reset is high. After
         // release, the first second appears on the 4th edge and no earlier.
         if (rst[0]) begin
            check("a_in_reset", tm[0], 24'h000000);
            rel_a = 0;
         end else begin
            rel_a++;
            if (rel_a == 3) check("a_not_early", tm[0], 24'h000000);
            if (rel_a == 4) check("a_first_sec", tm[0], 24'h000001);
         end

         // Instance 1: every carry up to the midnight wrap.
         exp_b = 24'hFFFFFF;
         case (k)
            59:     exp_b = 24'h000059;
            60:     exp_b = 24'h000100;
            3599:   exp_b = 24'h005959;
            3600:   exp_b = 24'h010000;
            35999:  exp_b = 24'h095959;
            36000:  exp_b = 24'h100000;
            86399:  exp_b = 24'h235959;
            86400:  exp_b = 24'h000000;
            86401:  exp_b = 24'h000001;
            default: exp_b = 24'hFFFFFF;
         endcase
         if (exp_b != 24'hFFFFFF) check($sformatf("b_at_%0d", k), tm[1], exp_b);

         // Instance 2: reset is asserted at 12:34:56 and lands on a tick edge.
         if (k == 45296) check("c_at_123456", tm[2], 24'h123456);
         if (k == 45297) check("c_reset_over_tick", tm[2], 24'h000000);
         rst[2] = (k == 45296);

         // Instance 0 reset schedule.
         if (k == held_start) hold_a = 3;
         if (!tick_rst_done && k >= 200 && hold_a == 0 && !rst[0] &&
             pcnt[0] == 3) begin
            // The model says the next edge carries a tick.
            hold_a        = 1;
            tick_rst_done = 1'b1;
         end
         if (k > 2000 && hold_a == 0 && $urandom_range(0, 999) == 0)
            hold_a = $urandom_range(1, 3);
         if (hold_a > 0) begin
            rst[0] = 1'b1;
            hold_a--;
         end else begin
            rst[0] = 1'b0;
         end
      end

      if (!tick_rst_done) check("a_tick_reset_ran", 24'd0, 24'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
